reset_sequencer: RTL

- Multi-channel successor to the single-domain reset generator. Sequences reset release for NUMBER_OF_CHANNELS downstream clock domains, each gated by its own PLL lock.
- Adds PLL-reset retry on lock timeout, staged per-channel release, and debounced lock-loss re-entry. Also keeps a saturating lock-loss counter and a sticky fault flag.
- Sits directly after the board-level clock/reset input, ahead of all PLLs and domain resets.

---
 rtl/reset_sequencer_pkg.sv | 26 ++
 rtl/reset_sequencer_pll_lock_synchronizer.sv | 42 ++++
 rtl/reset_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the multi-channel reset sequencer: state encoding,
// default cycle counts and a helper for sizing the shared timer.
package reset_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    localparam int DEFAULT_NUMBER_OF_CHANNELS   = 3;
    localparam int DEFAULT_POWER_ON_HOLD_CYCLES = 1000;
    localparam int DEFAULT_LOCK_TIMEOUT_CYCLES  = 500000;
    localparam int DEFAULT_STAGE_DELAY_CYCLES   = 64;
    localparam int DEFAULT_LOCK_DEBOUNCE_CYCLES = 4;
    localparam int DEFAULT_MAX_RETRIES          = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/reset_sequencer_pll_lock_synchronizer.sv
// Per-channel PLL lock conditioning: 2-flop synchronizer followed by a
// consecutive-low debounce counter that flags a lock loss while enabled.
module pll_lock_synchronizer #(
    parameter int LOCK_DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_lock_raw,
    input  logic i_debounce_en,
    output logic o_locked_sync,
    output logic o_lock_lost
);

    localparam int DW = $clog2(LOCK_DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] LAST_LOW = DW'(LOCK_DEBOUNCE_CYCLES - 1);

    logic          r_meta;
    logic          r_sync;
    logic [DW-1:0] r_low_cnt;

    // The counter holds the number of earlier consecutive low cycles, so the
    // current low cycle completing the run is the one that raises o_lock_lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta    <= 1'b0;
            r_sync    <= 1'b0;
            r_low_cnt <= '0;
        end else begin
            r_meta <= i_lock_raw;
            r_sync <= r_meta;
            if (!i_debounce_en || r_sync) begin
                r_low_cnt <= '0;
            end else if (r_low_cnt != LAST_LOW) begin
                r_low_cnt <= r_low_cnt + 1'b1;
            end
        end
    end

    assign o_locked_sync = r_sync;
    assign o_lock_lost   = i_debounce_en && !r_sync && (r_low_cnt == LAST_LOW);

endmodule

// File: rtl/reset_sequencer.sv
// Multi-channel reset sequencer: holds PLLs in reset, waits for lock with
// retry/fault, releases domain resets one by one and watches for lock loss.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int NUMBER_OF_CHANNELS   = DEFAULT_NUMBER_OF_CHANNELS,
    parameter int POWER_ON_HOLD_CYCLES = DEFAULT_POWER_ON_HOLD_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES  = DEFAULT_LOCK_TIMEOUT_CYCLES,
    parameter int STAGE_DELAY_CYCLES   = DEFAULT_STAGE_DELAY_CYCLES,
    parameter int LOCK_DEBOUNCE_CYCLES = DEFAULT_LOCK_DEBOUNCE_CYCLES,
    parameter int MAX_RETRIES          = DEFAULT_MAX_RETRIES,
    parameter int COUNTER_WIDTH        = $clog2(max3(POWER_ON_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES,
                                                     STAGE_DELAY_CYCLES) + 1)
) (
    input  logic                          upstream_clock,
    input  logic                          upstream_reset,
    input  logic [NUMBER_OF_CHANNELS-1:0] downstream_pll_locked,
    output logic                          pll_reset,
    output logic [NUMBER_OF_CHANNELS-1:0] downstream_reset,
    output logic                          all_ready,
    output logic                          timeout_error,
    output logic [7:0]                    lock_loss_count
);

    localparam int IDX_W   = (NUMBER_OF_CHANNELS > 1) ? $clog2(NUMBER_OF_CHANNELS) : 1;
    localparam int RETRY_W = $clog2(MAX_RETRIES + 2);

    localparam logic [COUNTER_WIDTH-1:0]      HOLD_LAST    = COUNTER_WIDTH'(POWER_ON_HOLD_CYCLES - 1);
    localparam logic [COUNTER_WIDTH-1:0]      TIMEOUT_LAST = COUNTER_WIDTH'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [COUNTER_WIDTH-1:0]      STAGE_LAST   = COUNTER_WIDTH'(STAGE_DELAY_CYCLES - 1);
    localparam logic [IDX_W-1:0]              IDX_LAST     = IDX_W'(NUMBER_OF_CHANNELS - 1);
    localparam logic [RETRY_W-1:0]            RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);
    localparam logic [NUMBER_OF_CHANNELS-1:0] CH_ONE       = NUMBER_OF_CHANNELS'(1);

    state_t                          r_state;
    logic [COUNTER_WIDTH-1:0]        r_timer;
    logic [RETRY_W-1:0]              r_retries;
    logic [IDX_W-1:0]                r_idx;
    logic                            r_pll_reset;
    logic [NUMBER_OF_CHANNELS-1:0]   r_downstream_reset;
    logic                            r_all_ready;
    logic                            r_timeout_error;
    logic [7:0]                      r_lock_loss_count;

    logic [NUMBER_OF_CHANNELS-1:0]   w_locked;
    logic [NUMBER_OF_CHANNELS-1:0]   w_lock_lost;
    logic                            w_all_locked;
    logic                            w_debounce_en;
    logic [IDX_W-1:0]                w_idx_next;

    assign w_debounce_en = (r_state == ST_RUN);
    assign w_all_locked  = &w_locked;
    assign w_idx_next    = r_idx + 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < NUMBER_OF_CHANNELS; gi++) begin : g_ch
            pll_lock_synchronizer #(
                .LOCK_DEBOUNCE_CYCLES(LOCK_DEBOUNCE_CYCLES)
            ) u_lock_sync (
                .clk           (upstream_clock),
                .rst           (upstream_reset),
                .i_lock_raw    (downstream_pll_locked[gi]),
                .i_debounce_en (w_debounce_en),
                .o_locked_sync (w_locked[gi]),
                .o_lock_lost   (w_lock_lost[gi])
            );
        end
    endgenerate

    always_ff @(posedge upstream_clock or posedge upstream_reset) begin
        if (upstream_reset) begin
            r_state            <= ST_HOLD;
            r_timer            <= '0;
            r_retries          <= '0;
            r_idx              <= '0;
            r_pll_reset        <= 1'b1;
            r_downstream_reset <= '1;
            r_all_ready        <= 1'b0;
            r_timeout_error    <= 1'b0;
            r_lock_loss_count  <= '0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    r_pll_reset        <= 1'b1;
                    r_downstream_reset <= '1;
                    r_all_ready        <= 1'b0;
                    if (r_timer == HOLD_LAST) begin
                        r_state     <= ST_WAIT_LOCK;
                        r_timer     <= '0;
                        r_pll_reset <= 1'b0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock is checked first so it wins over a same-cycle timeout.
                    if (w_all_locked) begin
                        r_state            <= ST_RELEASE;
                        r_timer            <= '0;
                        r_idx              <= '0;
                        r_downstream_reset <= ~CH_ONE;
                    end else if (r_timer == TIMEOUT_LAST) begin
                        r_timer     <= '0;
                        r_pll_reset <= 1'b1;
                        if (r_retries < RETRY_LIMIT) begin
                            r_retries <= r_retries + 1'b1;
                            r_state   <= ST_HOLD;
                        end else begin
                            r_state         <= ST_FAULT;
                            r_timeout_error <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (!w_all_locked) begin
                        r_state            <= ST_HOLD;
                        r_timer            <= '0;
                        r_pll_reset        <= 1'b1;
                        r_downstream_reset <= '1;
                    end else if (r_idx == IDX_LAST) begin
                        r_state     <= ST_RUN;
                        r_timer     <= '0;
                        r_retries   <= '0;
                        r_all_ready <= 1'b1;
                    end else if (r_timer == STAGE_LAST) begin
                        r_timer            <= '0;
                        r_idx              <= w_idx_next;
                        r_downstream_reset <= r_downstream_reset & ~(CH_ONE << w_idx_next);
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (|w_lock_lost) begin
                        r_state            <= ST_HOLD;
                        r_timer            <= '0;
                        r_pll_reset        <= 1'b1;
                        r_downstream_reset <= '1;
                        r_all_ready        <= 1'b0;
                        if (r_lock_loss_count != 8'hFF) begin
                            r_lock_loss_count <= r_lock_loss_count + 1'b1;
                        end
                    end
                end
                ST_FAULT: begin
                    r_pll_reset        <= 1'b1;
                    r_downstream_reset <= '1;
                    r_all_ready        <= 1'b0;
                    r_timeout_error    <= 1'b1;
                end
                default: begin
                    r_state <= ST_HOLD;
                    r_timer <= '0;
                end
            endcase
        end
    end

    assign pll_reset        = r_pll_reset;
    assign downstream_reset = r_downstream_reset;
    assign all_ready        = r_all_ready;
    assign timeout_error    = r_timeout_error;
    assign lock_loss_count  = r_lock_loss_count;

endmodule
